// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Byte-stream program loader for the instruction memory. A host link supplies
// a framed byte stream over a valid/ready handshake:
//
//   N (1..255 words, 0 = 256) | {LO, HI} x N | checksum
//
// Each LO/HI pair is packed into a 9-bit instruction word {HI[0], LO}. The
// word is written to consecutive instruction-memory addresses, starting at
// BASE_ADDR and wrapping modulo 256. The checksum byte must equal the XOR of
// every earlier byte in the frame, including N. Any HI byte with a non-zero
// value in bits [7:1] aborts the load before its word is written.
//
// The processor core is held (cpu_hold = 1) from reset until a load completes
// cleanly. Words written before a failure are not rolled back; cpu_hold stays
// high after an error, so the core never runs a partial image.
//
// Ports
//   clk       in   rising-edge clock for all logic
//   reset_n   in   synchronous active-low reset
//   start     in   begin a new load (honored only in IDLE, DONE or ERROR)
//   in_data   in   [7:0] stream byte
//   in_valid  in   in_data is valid
//   in_ready  out  loader accepts a byte; transfer = in_valid && in_ready
//   wr_en     out  one-cycle instruction-memory write strobe
//   wr_addr   out  [7:0] write address
//   wr_data   out  [8:0] write data (instruction word)
//   busy      out  a load is in progress
//   done      out  last load succeeded (sticky until the next start)
//   err       out  last load failed (sticky until the next start)
//   cpu_hold  out  keep the core halted with pc held at 0
//
// Every output is a flop. The output flops are loaded from a decode of the
// next state, so each output changes on the same edge as the state it
// describes.
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_LO,
    S_HI,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q,     state_d;
  logic [7:0]  addr_q,      addr_d;       // address of the next word to write
  logic [8:0]  remaining_q, remaining_d;  // words still to write (1..256)
  logic [7:0]  csum_q,      csum_d;       // running XOR of the frame bytes
  logic [7:0]  lo_q,        lo_d;         // low byte of the word being built
  logic [8:0]  wr_data_q,   wr_data_d;
  logic        wr_en_q,     wr_en_d;
  logic        in_ready_q,  in_ready_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        err_q,       err_d;
  logic        cpu_hold_q,  cpu_hold_d;

  // A byte is consumed only when the host offers it and the loader is ready.
  // in_ready_q is a registered state decode, so this is never a combinational
  // path from in_valid back to in_ready.
  logic xfer;
  assign xfer = in_valid && in_ready_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    csum_d      = csum_q;
    lo_d        = lo_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_COUNT;
          addr_d      = BASE_ADDR;
          remaining_d = 9'd0;
          csum_d      = 8'd0;
        end
      end

      S_COUNT: begin
        if (xfer) begin
          // A count byte of zero encodes a full 256-word image.
          remaining_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          csum_d      = csum_q ^ in_data;
          state_d     = S_LO;
        end
      end

      S_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_HI;
        end
      end

      S_HI: begin
        if (xfer) begin
          if (in_data[7:1] != 7'd0) begin
            // Malformed high byte: abort before anything reaches memory.
            state_d = S_ERROR;
          end else begin
            wr_data_d = {in_data[0], lo_q};
            csum_d    = csum_q ^ in_data;
            state_d   = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        // The strobe for this word is already on the outputs during this
        // cycle; advance the address (8-bit wrap) for the next word.
        addr_d      = addr_q + 8'd1;
        remaining_d = remaining_q - 9'd1;
        state_d     = (remaining_q > 9'd1) ? S_LO : S_CHECK;
      end

      S_CHECK: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode of the next state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_d = (state_d == S_COUNT) || (state_d == S_LO) ||
                 (state_d == S_HI)    || (state_d == S_CHECK);
    busy_d     = (state_d == S_COUNT) || (state_d == S_LO)    ||
                 (state_d == S_HI)    || (state_d == S_WRITE) ||
                 (state_d == S_CHECK);
    wr_en_d    = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
    // The core is released only after a clean load; a new start re-arms it.
    cpu_hold_d = (state_d != S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Reset is synchronous. It also clears wr_en_q, so a reset taken on the edge
  // that would start a WRITE cycle prevents that write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and the order of statements within
    // this block does not matter.
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE_ADDR;
      remaining_q <= 9'd0;
      csum_q      <= 8'd0;
      lo_q        <= 8'd0;
      wr_data_q   <= 9'd0;
      wr_en_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      csum_q      <= csum_d;
      lo_q        <= lo_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // addr_q advances only when WRITE ends, so it holds the write address for the
  // whole WRITE cycle.
  assign wr_addr  = addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. A driver task streams frames through
// the valid/ready handshake. When a HI byte is driven, the driver pushes the
// expected memory write into a scoreboard queue. A negedge monitor pops one
// entry for each wr_en pulse and compares the address and data. Status
// outputs are compared against constants at the end of each frame.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam logic [7:0] BASE = 8'd4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic       cpu_hold;

  prog_loader #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [8:0] data;
  } wr_t;

  wr_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         xfer_cyc = 0;
  int         first_cyc = 0;
  int         end_cyc = 0;
  logic [7:0] addr_exp = BASE;
  logic [7:0] last_wr_addr = 8'd0;
  logic       wr_en_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write, and no
  // strobe may last two consecutive cycles.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
      check("wr_pulse_len", wr_en_prev, 0);
      last_wr_addr = wr_addr;
    end
    wr_en_prev = wr_en;
  end

  // Offer one byte and hold it until the handshake completes. in_ready is
  // sampled at the negedge; the transfer happens on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        xfer_cyc = cyc;
        ok       = 1'b1;
      end
    end
    if (!ok) check("xfer_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Stream a frame. gap inserts an idle cycle after every byte. start_on_hi
  // raises start while HI bytes are being offered; the loader must ignore it.
  task automatic send_frame(input logic [7:0] b[$], input bit gap, input bit start_on_hi);
    int n;
    n = (b[0] == 8'd0) ? 256 : int'(b[0]);
    for (int k = 0; k < b.size(); k++) begin
      bit         is_hi;
      logic [7:0] hb;
      hb    = b[k];
      is_hi = (k >= 2) && (k <= 2 * n) && (k % 2 == 0);
      if (is_hi && hb[7:1] == 7'd0) begin
        sb.push_back('{addr_exp, {hb[0], b[k-1]}});
        addr_exp = addr_exp + 8'd1;
      end
      if (is_hi && start_on_hi) start = 1'b1;
      send_byte(hb);
      start = 1'b0;
      if (k == 0) first_cyc = xfer_cyc;
      if (is_hi && hb[7:1] != 7'd0) break;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic start_load();
    addr_exp = BASE;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_hold", cpu_hold, 1);
    check("start_done", done, 0);
    check("start_err", err, 0);
    check("start_ready", in_ready, 1);
  endtask

  task automatic wait_end(input bit exp_done, input bit exp_err);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (done || err) begin
        seen    = 1'b1;
        end_cyc = cyc;
      end
    end
    check("end_seen", seen, 1);
    check("end_done", done, exp_done);
    check("end_err", err, exp_err);
    check("end_hold", cpu_hold, !exp_done);
    check("end_ready", in_ready, 0);
    check("end_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, BASE);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_hold"}, cpu_hold, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] good[$];
    logic [7:0] bad_hi[$];
    logic [7:0] bad_cs[$];
    logic [7:0] big[$];
    logic [7:0] x;
    logic [8:0] w;

    good   = '{8'h02, 8'h20, 8'h00, 8'h6D, 8'h00, 8'h4F};
    bad_hi = '{8'h01, 8'h23, 8'h02};
    bad_cs = '{8'h01, 8'h22, 8'h01, 8'h00};

    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Good load with continuous valid; DONE is entered 7 edges after the
    // first transfer, which the negedge sampler sees 8 cycles later.
    start_load();
    send_frame(good, 1'b0, 1'b0);
    wait_end(1'b1, 1'b0);
    check("done_latency", end_cyc - first_cyc, 8);

    // Same frame under backpressure.
    start_load();
    send_frame(good, 1'b1, 1'b0);
    wait_end(1'b1, 1'b0);

    // Bad HI byte: no write, error, core stays held.
    start_load();
    send_frame(bad_hi, 1'b0, 1'b0);
    wait_end(1'b0, 1'b1);

    // Checksum mismatch after one write of 9'h122.
    start_load();
    send_frame(bad_cs, 1'b0, 1'b0);
    wait_end(1'b0, 1'b1);

    // Reset after the first LO byte, then a clean reload.
    start_load();
    send_byte(8'h02);
    send_byte(8'h20);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_values("midrst");
    start_load();
    send_frame(good, 1'b0, 1'b0);
    wait_end(1'b1, 1'b0);

    // start pulsed while in HI is ignored.
    start_load();
    send_frame(good, 1'b0, 1'b1);
    wait_end(1'b1, 1'b0);

    // 256-word frame from DONE: addresses BASE..255 then wrap to BASE-1.
    big.push_back(8'h00);
    x = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = 9'($urandom_range(0, 511));
      big.push_back(w[7:0]);
      big.push_back({7'd0, w[8]});
      x = x ^ w[7:0] ^ {7'd0, w[8]};
    end
    big.push_back(x);
    start_load();
    send_frame(big, 1'b0, 1'b0);
    wait_end(1'b1, 1'b0);
    check("wrap_last_addr", last_wr_addr, BASE - 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
